// File: rtl/ifetch_unit_pkg.sv
// Shared types and constants for the instruction fetch front end.
package ifetch_unit_pkg;

  localparam int unsigned INS_W = 32;
  localparam logic [INS_W-1:0] PC_START_DEFAULT = 32'h0040_0020;
  localparam logic [INS_W-1:0] NOP_INS = 32'h0000_0000;

  typedef struct packed {
    logic [INS_W-1:0] ins;
    logic [INS_W-1:0] pc;
  } fetch_entry_t;

  function automatic logic [INS_W-1:0] pc_plus4(input logic [INS_W-1:0] pc);
    return pc + INS_W'(4);
  endfunction

endpackage

// File: rtl/ifetch_fifo.sv
// Circular buffer of fetched {ins, pc} entries; pointers carry one extra wrap bit.
module ifetch_fifo
  import ifetch_unit_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  input  logic         flush,
  output logic         full,
  output logic         empty,
  output logic [AW:0]  count,
  output fetch_entry_t head
);

  fetch_entry_t mem [DEPTH];
  logic [AW:0]  wr_q;
  logic [AW:0]  rd_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_q <= '0;
      rd_q <= '0;
    end else if (flush) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + (AW+1)'(1);
      if (pop)  rd_q <= rd_q + (AW+1)'(1);
    end
  end

  // Storage needs no reset; empty masks it at the outputs.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_q[AW-1:0]] <= push_data;
  end

  assign count = wr_q - rd_q;
  assign empty = (count == '0);
  assign full  = (count == (AW+1)'(DEPTH));
  assign head  = mem[rd_q[AW-1:0]];

endmodule

// File: rtl/ifetch_unit.sv
// Sequential instruction fetch with credit-limited requests, redirect/reload flush.
// Optional IFETCH_PERF_EN adds perf_fetched / perf_flushed counters.
module ifetch_unit
  import ifetch_unit_pkg::*;
#(
  parameter logic [31:0] PC_START = PC_START_DEFAULT,
  parameter int unsigned DEPTH    = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_pc,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic        ins_valid,
  input  logic        ins_ready,
  output logic [31:0] ins,
  output logic [31:0] ins_pc,
  output logic [31:0] ins_pc4,
`ifdef IFETCH_PERF_EN
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_flushed,
`endif
  output logic [31:0] fetch_pc
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 2;

  logic [31:0]  fetch_q;
  logic         inflight_q;
  logic [31:0]  inflight_pc_q;

  logic         flush_c;
  logic         pop_c;
  logic         push_c;
  logic         room_c;
  logic         req_c;
  logic [CW-1:0] used_c;
  logic [31:0]  flush_pc_c;

  logic         full_w;
  logic         empty_w;
  logic [AW:0]  count_w;
  fetch_entry_t head_w;
  fetch_entry_t push_data_w;

  assign flush_c    = load_pc | redirect;
  assign pop_c      = ins_valid & ins_ready;
  assign push_c     = inflight_q & ~flush_c;
  assign flush_pc_c = load_pc ? PC_START : (redirect_pc & ~32'd3);

  // A pop in this cycle returns its credit immediately.
  assign used_c = CW'(count_w) + CW'(inflight_q) - CW'(pop_c);
  assign room_c = ~full_w | pop_c;
  assign req_c  = reset & ~flush_c & room_c & (used_c < CW'(DEPTH));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_q       <= PC_START;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else if (flush_c) begin
      fetch_q    <= flush_pc_c;
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= req_c;
      if (req_c) begin
        inflight_pc_q <= fetch_q;
        fetch_q       <= pc_plus4(fetch_q);
      end
    end
  end

  assign push_data_w.ins = imem_rdata;
  assign push_data_w.pc  = inflight_pc_q;

  ifetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push_c),
    .push_data (push_data_w),
    .pop       (pop_c),
    .flush     (flush_c),
    .full      (full_w),
    .empty     (empty_w),
    .count     (count_w),
    .head      (head_w)
  );

  assign imem_req  = req_c;
  assign imem_addr = fetch_q;
  assign fetch_pc  = fetch_q;
  assign ins_valid = ~empty_w;
  assign ins       = empty_w ? NOP_INS : head_w.ins;
  assign ins_pc    = empty_w ? 32'h0 : head_w.pc;
  assign ins_pc4   = pc_plus4(ins_pc);

`ifdef IFETCH_PERF_EN
  // Flushed count excludes a head that transfers in the flush cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_fetched <= '0;
      perf_flushed <= '0;
    end else begin
      if (pop_c) perf_fetched <= perf_fetched + 32'd1;
      if (flush_c) perf_flushed <= perf_flushed + 32'(count_w) + 32'(inflight_q) - 32'(pop_c);
    end
  end
`endif

endmodule
